// File: rtl/shift_seq_r_if.sv
// Request/result handshake bundle between ALU issue logic and the shift sequencer.
interface shift_seq_r_if #(
  parameter int word_width   = 8,
  parameter int amount_width = 6
);
  logic                    IN_VALID;
  logic                    IN_READY;
  logic [word_width-1:0]   D_IN;
  logic [word_width-2:0]   C_IN;
  logic [amount_width-1:0] shift_amount;
  logic [1:0]              shift_type;
  logic                    OUT_VALID;
  logic                    OUT_READY;
  logic [word_width-1:0]   D_OUT;
  logic [word_width-2:0]   C_OUT;
  logic                    BUSY;

  modport master (
    output IN_VALID, D_IN, C_IN, shift_amount, shift_type, OUT_READY,
    input  IN_READY, OUT_VALID, D_OUT, C_OUT, BUSY
  );

  modport slave (
    input  IN_VALID, D_IN, C_IN, shift_amount, shift_type, OUT_READY,
    output IN_READY, OUT_VALID, D_OUT, C_OUT, BUSY
  );
endinterface

// File: rtl/shift_seq_r.sv
// Multi-cycle right-shift sequencer (LSR/ASR/RCR/ROR), at most 7 bits per SHIFT cycle.
// Latency max(1,ceil(amount/7)) SHIFT cycles; result held in DONE until OUT_READY.
module shift_seq_r #(
  parameter int word_width   = 8,
  parameter int amount_width = 6
) (
  input  logic         CLK,
  input  logic         RST,
  shift_seq_r_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] T_LSR = 2'd0;
  localparam logic [1:0] T_ASR = 2'd1;
  localparam logic [1:0] T_RCR = 2'd2;
  localparam logic [1:0] T_ROR = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [word_width-1:0]   d_q, d_d;
  logic [word_width-2:0]   c_q, c_d;
  logic [amount_width-1:0] rem_q, rem_d;
  logic [1:0]              type_q, type_d;

  logic [2:0]              step;
  logic [word_width-1:0]   sd;
  logic [word_width-2:0]   sc;

  always_comb begin
    step = (rem_q > amount_width'(7)) ? 3'd7 : 3'(rem_q);
  end

  // One pass of the shifter: apply 'step' single-bit moves so every step width composes exactly.
  always_comb begin
    sd = d_q;
    sc = c_q;
    for (int i = 0; i < 7; i++) begin
      if (i < int'(step)) begin
        case (type_q)
          T_LSR:   sd = {1'b0, sd[word_width-1:1]};
          T_ASR:   sd = {sd[word_width-1], sd[word_width-1:1]};
          T_RCR: begin
            sd = {sc[0], sd[word_width-1:1]};
            sc = sc >> 1;
          end
          T_ROR:   sd = {sd[0], sd[word_width-1:1]};
          default: sd = d_q;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    c_d     = c_q;
    rem_d   = rem_q;
    type_d  = type_q;
    case (state_q)
      S_IDLE: begin
        if (bus.IN_VALID) begin
          d_d     = bus.D_IN;
          c_d     = bus.C_IN;
          rem_d   = bus.shift_amount;
          type_d  = bus.shift_type;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        d_d   = sd;
        rem_d = rem_q - amount_width'(step);
        if (type_q == T_RCR) begin
          c_d = sc;
        end
        // An amount of zero still takes this one cycle with step 0.
        if (rem_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.OUT_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      c_q     <= '0;
      rem_q   <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      c_q     <= c_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
    end
  end

  assign bus.IN_READY  = (state_q == S_IDLE);
  assign bus.OUT_VALID = (state_q == S_DONE);
  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.D_OUT     = d_q;
  assign bus.C_OUT     = (type_q == T_RCR) ? c_q : '0;

endmodule

// File: tb/tb_shift_seq_r.sv
// Directed bench for shift_seq_r: result values, SHIFT-cycle latency, backpressure and async reset.
module tb_shift_seq_r;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  shift_seq_r_if #(.word_width(8), .amount_width(6)) bus ();

  shift_seq_r #(.word_width(8), .amount_width(6)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present a request and let the next rising edge accept it.
  task automatic start(input logic [1:0] t, input logic [7:0] d, input logic [6:0] c,
                       input logic [5:0] amt, input string tag);
    bus.IN_VALID     = 1'b1;
    bus.shift_type   = t;
    bus.D_IN         = d;
    bus.C_IN         = c;
    bus.shift_amount = amt;
    chk({tag, "_in_ready"}, 32'(bus.IN_READY), 32'd1);
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
    bus.D_IN     = 8'h00;
    bus.C_IN     = 7'h00;
  endtask

  task automatic wait_result(input logic [7:0] exp_d, input logic [6:0] exp_c,
                             input int n_shift, input string tag);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.OUT_VALID && cnt < 30);
    chk({tag, "_latency"}, 32'(cnt), 32'(n_shift + 1));
    chk({tag, "_out_valid"}, 32'(bus.OUT_VALID), 32'd1);
    chk({tag, "_d_out"}, 32'(bus.D_OUT), 32'(exp_d));
    chk({tag, "_c_out"}, 32'(bus.C_OUT), 32'(exp_c));
  endtask

  task automatic handshake(input string tag);
    bus.OUT_READY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle_out_valid"}, 32'(bus.OUT_VALID), 32'd0);
    chk({tag, "_idle_in_ready"}, 32'(bus.IN_READY), 32'd1);
  endtask

  task automatic run_op(input logic [1:0] t, input logic [7:0] d, input logic [6:0] c,
                        input logic [5:0] amt, input logic [7:0] exp_d, input logic [6:0] exp_c,
                        input int n_shift, input string tag);
    bus.OUT_READY = 1'b1;
    start(t, d, c, amt, tag);
    wait_result(exp_d, exp_c, n_shift, tag);
    handshake(tag);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    bus.IN_VALID     = 1'b0;
    bus.D_IN         = 8'h00;
    bus.C_IN         = 7'h00;
    bus.shift_amount = 6'd0;
    bus.shift_type   = 2'd0;
    bus.OUT_READY    = 1'b1;

    #12;
    chk("rst_in_ready", 32'(bus.IN_READY), 32'd1);
    chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_d_out", 32'(bus.D_OUT), 32'd0);
    chk("rst_c_out", 32'(bus.C_OUT), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // C_IN is non-zero on LSR to show C_OUT is forced to zero for non-RCR types.
    run_op(2'd0, 8'hB4, 7'h7F, 6'd3,  8'h16, 7'h00, 1, "lsr3");
    run_op(2'd1, 8'h80, 7'h00, 6'd20, 8'hFF, 7'h00, 3, "asr20");
    run_op(2'd1, 8'h80, 7'h00, 6'd0,  8'h80, 7'h00, 1, "asr0");
    run_op(2'd3, 8'h81, 7'h00, 6'd9,  8'hC0, 7'h00, 2, "ror9");
    run_op(2'd3, 8'h81, 7'h00, 6'd16, 8'h81, 7'h00, 3, "ror16");
    run_op(2'd2, 8'h00, 7'h55, 6'd4,  8'h50, 7'h05, 1, "rcr4");
    run_op(2'd2, 8'h00, 7'h55, 6'd15, 8'h00, 7'h00, 3, "rcr15");
    run_op(2'd0, 8'hFF, 7'h00, 6'd8,  8'h00, 7'h00, 2, "lsr8");
    run_op(2'd2, 8'h01, 7'h40, 6'd7,  8'h80, 7'h00, 1, "rcr7");

    // Backpressure: result must hold and new requests stay blocked while OUT_READY is low.
    bus.OUT_READY = 1'b0;
    start(2'd3, 8'h81, 7'h00, 6'd3, "bp");
    wait_result(8'h30, 7'h00, 1, "bp");
    bus.IN_VALID     = 1'b1;
    bus.shift_type   = 2'd0;
    bus.D_IN         = 8'hFF;
    bus.shift_amount = 6'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.OUT_VALID), 32'd1);
      chk("bp_hold_d_out", 32'(bus.D_OUT), 32'h30);
      chk("bp_hold_in_ready", 32'(bus.IN_READY), 32'd0);
    end
    bus.OUT_READY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 32'(bus.IN_READY), 32'd1);
    chk("bp_release_out_valid", 32'(bus.OUT_VALID), 32'd0);
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
    wait_result(8'h7F, 7'h00, 1, "bp_next");
    handshake("bp_next");

    // Asynchronous reset in the middle of a long ASR.
    start(2'd1, 8'h80, 7'h00, 6'd63, "rst_mid");
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_busy", 32'(bus.BUSY), 32'd1);
    chk("mid_in_ready", 32'(bus.IN_READY), 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.BUSY), 32'd0);
    chk("arst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("arst_d_out", 32'(bus.D_OUT), 32'd0);
    chk("arst_in_ready", 32'(bus.IN_READY), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_still_idle", 32'(bus.OUT_VALID), 32'd0);
    run_op(2'd1, 8'h80, 7'h00, 6'd63, 8'hFF, 7'h00, 9, "asr63");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq_r.md
# shift_seq_r

Multi-cycle sequencer for the `polyshift_r` right-shift datapath. `polyshift_r` moves at most 7 bits per pass, so this block accepts shift amounts up to `2**amount_width - 1`. It iterates one instance of `polyshift_r` once per clock, stepping at most 7 bits each time, and holds the running data and carry words in registers. It sits between the ALU issue logic and the shifter, and presents a valid/ready handshake on both sides.

## Interface
- `word_width`, 8: data width; must be ≥ 2.
- `amount_width`, 6: width of the requested shift amount.

- `CLK`  in  1  the block's single clock.
- `RST`  in  1  reset; asynchronous and active-high.
- `IN_VALID`  in  1  request present.
- `IN_READY`  out  1  request accepted when `IN_VALID && IN_READY` on a rising edge of `CLK`.
- `D_IN`  in  `word_width`  operand.
- `C_IN`  in  `word_width-1`  upper (double-precision) word; used by RCR only.
- `shift_amount`  in  `amount_width`  total shift distance.
- `shift_type`  in  `SHIFT_TYPE`  0 = LSR, 1 = ASR, 2 = RCR, 3 = ROR.
- `OUT_VALID`  out  1  result present.
- `OUT_READY`  in  1  result consumed when `OUT_VALID && OUT_READY`.
- `D_OUT`  out  `word_width`  result word.
- `C_OUT`  out  `word_width-1`  remaining upper word (RCR); zero for other types.
- `BUSY`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `IN_READY` = 1.
  - On accept, latch `D_IN`→`d_r`, `C_IN`→`c_r`, `shift_amount`→`rem_r`, `shift_type`→`type_r`, then go to SHIFT.
- **SHIFT**
  - `step = min(rem_r, 7)`; drive `polyshift_r` with `D_IN=d_r`, `C_IN=c_r`, `shift_size=step`, `shift_type=type_r`.
  - Register `d_r <= psr.D_OUT` and `rem_r <= rem_r - step`.
  - If `type_r` is RCR: `c_r <= c_r >> step` (zero fill). Otherwise `c_r` is held, then forced to 0 on output.
  - If `rem_r - step == 0`, go to DONE; otherwise stay in SHIFT.
  - An amount of 0 still spends one SHIFT cycle with step 0 and leaves the data unchanged.
- **DONE**
  - `OUT_VALID` = 1; `D_OUT = d_r`; `C_OUT = (type_r==RCR) ? c_r : 0`.
  - On `OUT_READY` go to IDLE. There is no same-cycle re-accept.
- **Type semantics:** the composition of steps equals one shift by the full amount.
  - LSR: amount ≥ `word_width` gives 0.
  - ASR: amount ≥ `word_width` gives all copies of the sign bit.
  - ROR: result is rotate by `amount mod word_width`.
  - RCR: `{C,D}` (2·`word_width`−1 bits) shifted right with zero fill; amount ≥ 2·`word_width`−1 gives D=0, C=0.
- Inputs are ignored outside IDLE. `D_IN`/`C_IN` need only be stable in the accept cycle.

## Timing
- **Reset:** `RST` high asynchronously forces state IDLE and clears `d_r`, `c_r`, `rem_r`, `type_r` to 0. This holds mid-SHIFT or in DONE; the in-flight operation is discarded with no output.
- **Output reset values:** `IN_READY`=1 (IDLE), `OUT_VALID`=0, `D_OUT`=0, `C_OUT`=0, `BUSY`=0.
- **SHIFT cycles:** N = max(1, ⌈amount/7⌉).
- **Latency:** accept edge at cycle 0 → `OUT_VALID` high from cycle N+1.
- **Backpressure:** with `OUT_READY` low, the block stays in DONE, holds `D_OUT`/`C_OUT` stable and keeps `IN_READY`=0.
- **Throughput:** the next accept is possible no earlier than the cycle after the output handshake.
- **Maximum latency:** amount = 2**`amount_width`−1 = 63 → 9 SHIFT cycles (steps 7×9).
- **All outputs are registered state or decoded from it;** no combinational path from inputs to outputs.

## Test plan
(`word_width`=8.)
- LSR, D=0xB4, amount=3, `OUT_READY`=1 → `D_OUT`=0x16, `C_OUT`=0, `OUT_VALID` two cycles after accept (1 SHIFT cycle).
- ASR, D=0x80, amount=20 → SHIFT steps 7,7,6 (3 cycles), `D_OUT`=0xFF. Repeat with amount=0 → 1 SHIFT cycle, `D_OUT`=0x80.
- ROR, D=0x81, amount=9 → steps 7,2, `D_OUT`=0xC0. Amount=16 → `D_OUT`=0x81.
- RCR, D=0x00, C=7'h55, amount=4 → `D_OUT`=0x50, `C_OUT`=7'h05. Amount=15 → `D_OUT`=0x00, `C_OUT`=0.
- Backpressure: hold `OUT_READY`=0 for 5 cycles after `OUT_VALID` → result stable and `IN_READY`=0 throughout. A new `IN_VALID` is ignored until the cycle after `OUT_READY` is raised.
- Reset mid-SHIFT on ASR amount=63: pulse `RST` asynchronously (between edges) → `BUSY`/`OUT_VALID`/`D_OUT` go to 0 immediately and `IN_READY`=1. A following request completes normally.
